// File: rtl/approx_mult_err_sweep_if.sv
// Bus between the error-sweep engine and its surroundings: the operand
// pair driven to the approximate multiplier, the product coming back,
// start/busy/done control and the accumulated error statistics.
// master: the side that drives start and mult_p (controller + multiplier).
// slave : the sweep engine itself.
interface approx_mult_err_sweep_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       mult_a;
  logic [WIDTH-1:0]       mult_b;
  logic [2*WIDTH-1:0]     mult_p;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH:0]       err_count;
  logic [4*WIDTH-1:0]     sum_ed;
  logic [2*WIDTH-1:0]     max_ed;
  logic [WIDTH-1:0]       worst_a;
  logic [WIDTH-1:0]       worst_b;
  logic [4*WIDTH:0]       sum_err;

  modport master (
    output start, mult_p,
    input  mult_a, mult_b, busy, done, err_count, sum_ed, max_ed,
           worst_a, worst_b, sum_err
  );

  modport slave (
    input  start, mult_p,
    output mult_a, mult_b, busy, done, err_count, sum_ed, max_ed,
           worst_a, worst_b, sum_err
  );
endinterface

// File: rtl/approx_mult_err_sweep.sv
// Exhaustive error-characterisation engine for one approximate multiplier.
// Walks every operand pair (A inner loop, B outer loop), realigns the issued
// operands with the multiplier's product after MULT_LAT cycles, and
// accumulates error count, summed/maximum error distance and the first pair
// that reached the maximum.
// Optional feature macro: APPROX_SIGNED_ERR_EN -- when defined, sum_err
// accumulates the signed error (mult_p - a*b); otherwise sum_err reads 0.
module approx_mult_err_sweep #(
  parameter int WIDTH    = 8,
  parameter int MULT_LAT = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  approx_mult_err_sweep_if.slave bus
);

  localparam int PW  = 2 * WIDTH;               // product / index width
  localparam int TW  = PW + 1;                  // tag: {valid, b, a}
  localparam int DCW = $clog2(MULT_LAT + 2) + 1; // drain counter width

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PW-1:0]      r_idx;
  logic [DCW-1:0]     r_drain_cnt;
  logic [WIDTH-1:0]   r_mult_a;
  logic [WIDTH-1:0]   r_mult_b;
  logic               r_iss_valid;
  logic               r_done;
  logic               w_busy;
  logic               w_done_set;
  logic               w_idx_last;
  logic               w_start_acc;

  assign w_idx_last  = &r_idx;
  assign w_start_acc = (r_state == S_IDLE) && bus.start;

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: sweep all pairs, flush the pipeline, announce completion.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_SWEEP;
      S_SWEEP: if (w_idx_last) w_state_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == DCW'(MULT_LAT + 1)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    w_busy     = (r_state == S_SWEEP) || (r_state == S_DRAIN);
    w_done_set = (r_state == S_DONE);
  end

  // Operand issue: present idx each SWEEP cycle; operands hold afterwards.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx       <= '0;
      r_mult_a    <= '0;
      r_mult_b    <= '0;
      r_iss_valid <= 1'b0;
    end else begin
      r_iss_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) r_idx <= '0;
        S_SWEEP: begin
          r_mult_a    <= r_idx[WIDTH-1:0];
          r_mult_b    <= r_idx[PW-1:WIDTH];
          r_iss_valid <= 1'b1;
          if (!w_idx_last) r_idx <= r_idx + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Drain length counter, running only while in DRAIN.
  always_ff @(posedge CLK) begin
    if (RST)                    r_drain_cnt <= '0;
    else if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + DCW'(1);
    else                        r_drain_cnt <= '0;
  end

  // Registered completion pulse, one cycle after the DONE state.
  always_ff @(posedge CLK) begin
    if (RST) r_done <= 1'b0;
    else     r_done <= w_done_set;
  end

  // Tag delay line matching the multiplier latency (empty when MULT_LAT=0).
  logic [TW-1:0] w_tag_chain [MULT_LAT+1];
  logic [TW-1:0] w_al_tag;

  assign w_tag_chain[0] = {r_iss_valid, r_mult_b, r_mult_a};

  genvar gi;
  generate
    for (gi = 0; gi < MULT_LAT; gi++) begin : g_tag
      logic [TW-1:0] r_tag;
      // One latency stage of the operand tag; valid is cleared by reset.
      always_ff @(posedge CLK) begin
        if (RST) r_tag <= '0;
        else     r_tag <= w_tag_chain[gi];
      end
      assign w_tag_chain[gi+1] = r_tag;
    end
  endgenerate

  assign w_al_tag = w_tag_chain[MULT_LAT];

  logic             w_al_valid;
  logic [WIDTH-1:0] w_al_a;
  logic [WIDTH-1:0] w_al_b;

  assign w_al_valid = w_al_tag[TW-1];
  assign w_al_b     = w_al_tag[TW-2:WIDTH];
  assign w_al_a     = w_al_tag[WIDTH-1:0];

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [PW-1:0]    r_s1_p;
  logic [PW-1:0]    r_s1_exact;

  // Stage 1: capture the aligned pair with its product and the exact result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_p     <= '0;
      r_s1_exact <= '0;
    end else begin
      r_s1_valid <= w_al_valid;
      r_s1_a     <= w_al_a;
      r_s1_b     <= w_al_b;
      r_s1_p     <= bus.mult_p;
      r_s1_exact <= PW'(w_al_a) * PW'(w_al_b);
    end
  end

  // Signed difference (approx - exact) and its magnitude, which always
  // fits in PW bits because both operands are PW-bit unsigned.
  logic [PW:0]   w_sdiff;
  logic [PW-1:0] w_ed;

  assign w_sdiff = {1'b0, r_s1_p} - {1'b0, r_s1_exact};
  assign w_ed    = w_sdiff[PW] ? (~w_sdiff[PW-1:0] + PW'(1)) : w_sdiff[PW-1:0];

  logic [PW:0]        r_err_count;
  logic [4*WIDTH-1:0] r_sum_ed;
  logic [PW-1:0]      r_max_ed;
  logic [WIDTH-1:0]   r_worst_a;
  logic [WIDTH-1:0]   r_worst_b;

  // Stage 2: accumulate statistics; strict compare keeps the earliest worst pair.
  always_ff @(posedge CLK) begin
    if (RST || w_start_acc) begin
      r_err_count <= '0;
      r_sum_ed    <= '0;
      r_max_ed    <= '0;
      r_worst_a   <= '0;
      r_worst_b   <= '0;
    end else if (r_s1_valid) begin
      if (w_ed != '0) begin
        r_err_count <= r_err_count + (PW+1)'(1);
        r_sum_ed    <= r_sum_ed + (4*WIDTH)'(w_ed);
      end
      if (w_ed > r_max_ed) begin
        r_max_ed  <= w_ed;
        r_worst_a <= r_s1_a;
        r_worst_b <= r_s1_b;
      end
    end
  end

`ifdef APPROX_SIGNED_ERR_EN
  logic [4*WIDTH:0] r_sum_err;

  // Signed error accumulator for bias / mean-error evaluation.
  always_ff @(posedge CLK) begin
    if (RST || w_start_acc) r_sum_err <= '0;
    else if (r_s1_valid)    r_sum_err <= r_sum_err + {{(2*WIDTH){w_sdiff[PW]}}, w_sdiff};
  end

  assign bus.sum_err = r_sum_err;
`else
  assign bus.sum_err = '0;
`endif

  assign bus.mult_a    = r_mult_a;
  assign bus.mult_b    = r_mult_b;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.err_count = r_err_count;
  assign bus.sum_ed    = r_sum_ed;
  assign bus.max_ed    = r_max_ed;
  assign bus.worst_a   = r_worst_a;
  assign bus.worst_b   = r_worst_b;

endmodule

// File: tb/tb_approx_mult_err_sweep.sv
// Bench for approx_mult_err_sweep at WIDTH=4, MULT_LAT=2 (256-pair sweeps).
// A table-driven stub multiplier with a two-cycle registered output stands in
// for the approximate multiplier; tables are exact, single-error, zero or
// randomised. Expected statistics come from a plain nested-loop model over
// the same table.
module tb_approx_mult_err_sweep;

  localparam int W       = 4;
  localparam int LAT     = 2;
  localparam int PW      = 2 * W;
  localparam int NP      = 1 << PW;
  localparam int EXP_LAT = NP + LAT + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  approx_mult_err_sweep_if #(.WIDTH(W)) bus ();

  approx_mult_err_sweep #(.WIDTH(W), .MULT_LAT(LAT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Stub multiplier: table lookup, two registered stages of latency.
  logic [PW-1:0] p_tab [NP];
  logic [PW-1:0] stub_q1, stub_q2;
  always @(posedge clk) begin
    stub_q1 <= p_tab[{bus.mult_b, bus.mult_a}];
    stub_q2 <= stub_q1;
  end
  assign bus.mult_p = stub_q2;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  longint exp_err, exp_sed, exp_max, exp_wa, exp_wb, exp_serr;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Fill the stub table: 0 exact, 1 single error at (3,5), 2 zero,
  // 3 random sparse errors, 4 small over-estimates (many ties), 5 under-estimates.
  task automatic fill(input int mode);
    for (int b = 0; b < (1 << W); b++) begin
      for (int a = 0; a < (1 << W); a++) begin
        int ex;
        int p;
        int d;
        ex = a * b;
        case (mode)
          0: p = ex;
          1: p = (a == 3 && b == 5) ? 16 : ex;
          2: p = 0;
          3: p = ($urandom_range(99) < 30) ? int'($urandom_range(255)) : ex;
          4: p = ex + int'($urandom_range(2));
          default: begin
            d = int'($urandom_range(3));
            p = (ex >= d) ? ex - d : ex;
          end
        endcase
        p_tab[b * (1 << W) + a] = PW'(p);
      end
    end
  endtask

  // Reference: walk all pairs in sweep order and apply the statistics rules.
  task automatic model();
    exp_err = 0; exp_sed = 0; exp_max = 0; exp_wa = 0; exp_wb = 0; exp_serr = 0;
    for (int b = 0; b < (1 << W); b++) begin
      for (int a = 0; a < (1 << W); a++) begin
        longint ex;
        longint p;
        longint ed;
        ex = a * b;
        p  = p_tab[b * (1 << W) + a];
        ed = (ex > p) ? ex - p : p - ex;
        if (ed != 0) begin
          exp_err++;
          exp_sed += ed;
        end
        if (ed > exp_max) begin
          exp_max = ed;
          exp_wa  = a;
          exp_wb  = b;
        end
        exp_serr += p - ex;
      end
    end
`ifndef APPROX_SIGNED_ERR_EN
    exp_serr = 0;
`endif
  endtask

  task automatic check_stats(input string name);
    check($sformatf("%s.err_count", name), bus.err_count, exp_err);
    check($sformatf("%s.sum_ed", name), bus.sum_ed, exp_sed);
    check($sformatf("%s.max_ed", name), bus.max_ed, exp_max);
    check($sformatf("%s.worst_a", name), bus.worst_a, exp_wa);
    check($sformatf("%s.worst_b", name), bus.worst_b, exp_wb);
    check($sformatf("%s.sum_err", name), $signed(bus.sum_err), exp_serr);
  endtask

  // One sweep: start held for 'hold' samples, optional extra pulse mid-sweep.
  task automatic run_sweep(input string name, input int hold, input bit mid);
    int n;
    int dc0;
    dc0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (n < EXP_LAT + 50) begin
      @(negedge clk);
      bus.start = ((n + 1) < hold) || (mid && n == 100);
      @(posedge clk); #1;
      n++;
      if (n == 50) check($sformatf("%s.busy_mid", name), bus.busy, 1);
      if (bus.done === 1'b1) break;
    end
    bus.start = 1'b0;
    check($sformatf("%s.latency", name), n, EXP_LAT);
    check($sformatf("%s.busy_at_done", name), bus.busy, 0);
    check_stats(name);
    $display("sweep %s: latency=%0d err_count=%0d sum_ed=%0d max_ed=%0d worst=(%0d,%0d) sum_err=%0d",
             name, n, bus.err_count, bus.sum_ed, bus.max_ed, bus.worst_a, bus.worst_b,
             $signed(bus.sum_err));
    @(posedge clk); #1;
    check($sformatf("%s.done_pulse", name), bus.done, 0);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s.done_count", name), done_cnt - dc0, 1);
    check($sformatf("%s.mult_a_hold", name), bus.mult_a, (1 << W) - 1);
    check($sformatf("%s.mult_b_hold", name), bus.mult_b, (1 << W) - 1);
    check($sformatf("%s.err_hold", name), bus.err_count, exp_err);
  endtask

  task automatic check_all_zero(input string name);
    check($sformatf("%s.mult_a", name), bus.mult_a, 0);
    check($sformatf("%s.mult_b", name), bus.mult_b, 0);
    check($sformatf("%s.busy", name), bus.busy, 0);
    check($sformatf("%s.done", name), bus.done, 0);
    check($sformatf("%s.err_count", name), bus.err_count, 0);
    check($sformatf("%s.sum_ed", name), bus.sum_ed, 0);
    check($sformatf("%s.max_ed", name), bus.max_ed, 0);
    check($sformatf("%s.worst_a", name), bus.worst_a, 0);
    check($sformatf("%s.worst_b", name), bus.worst_b, 0);
    check($sformatf("%s.sum_err", name), $signed(bus.sum_err), 0);
  endtask

  initial begin
    int dc0;
    bus.start = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    fill(0); model(); run_sweep("exact", 1, 1'b0);
    fill(1); model(); run_sweep("single_err", 1, 1'b0);
    fill(2); model(); run_sweep("zero", 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      fill(3); model(); run_sweep($sformatf("random%0d", k), 1, 1'b0);
    end
    fill(4); model(); run_sweep("ties_over", 1, 1'b0);
    fill(5); model(); run_sweep("under", 1, 1'b0);

    // Abort mid-sweep with a one-cycle reset.
    fill(2); model();
    dc0 = done_cnt;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (100) @(negedge clk);
    check("abort.busy_before", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("abort");
    repeat (EXP_LAT + 20) @(negedge clk);
    check("abort.no_done", done_cnt - dc0, 0);
    check("abort.idle_busy", bus.busy, 0);
    check("abort.err_idle", bus.err_count, 0);
    run_sweep("zero_after_abort", 1, 1'b0);

    // Long start and a mid-sweep start give the same single sweep.
    fill(3); model();
    run_sweep("rand_single", 1, 1'b0);
    run_sweep("rand_hold_mid", 10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_mult_err_sweep.md
Name: approx_mult_err_sweep

Overview:
- Exhaustive error-characterisation engine wrapped around one approximate multiplier instance (e.g. Mingtao_hybrid).
- Upstream role: drives every operand pair to the multiplier.
- Downstream role: consumes the multiplier's 16-bit product, compares it against the exact product, and accumulates error statistics.
- Used for on-chip / FPGA evaluation of each approximate multiplier variant in the thesis design set.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- MULT_LAT, 0, cycles from mult_a/mult_b change to a valid mult_p (0 = combinational multiplier).

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-high reset
- start  input  1  begin sweep; sampled only in IDLE
- mult_a  output  WIDTH  operand A to multiplier (registered)
- mult_b  output  WIDTH  operand B to multiplier (registered)
- mult_p  input  2*WIDTH  approximate product from multiplier
- busy  output  1  high in SWEEP and DRAIN
- done  output  1  one-cycle pulse when results are final
- err_count  output  2*WIDTH+1  number of pairs with mult_p != a*b
- sum_ed  output  4*WIDTH  sum of |a*b - mult_p|
- max_ed  output  2*WIDTH  largest error distance seen
- worst_a  output  WIDTH  operand A of first pair reaching max_ed
- worst_b  output  WIDTH  operand B of first pair reaching max_ed
- sum_err  output  4*WIDTH+1  signed sum of (mult_p - a*b); see optional feature

Behaviour:
- Reset: state IDLE. All outputs 0: mult_a, mult_b, busy, done, all statistics.
- RST mid-sweep aborts immediately to the reset condition; no done pulse.
- FSM states: IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 -> SWEEP. Clear index counter idx (2*WIDTH bits) and all statistics on the same edge.
  - start while busy or in DONE is ignored.
- SWEEP:
  - Each cycle, mult_a=idx[WIDTH-1:0] and mult_b=idx[2*WIDTH-1:WIDTH]; A is the inner loop, so order is (0,0),(1,0)..(255,0),(0,1)..
  - idx increments every cycle.
  - Leave SWEEP after the cycle presenting idx = all-ones; wrap to 0 is not issued.
  - SWEEP lasts exactly 2^(2*WIDTH) cycles.
- Operand tag pipeline: issued {a,b,valid} is delayed MULT_LAT cycles and aligned with mult_p, then:
  - Stage 1 (register): capture a, b, mult_p; compute exact = a*b (2*WIDTH bits, unsigned).
  - Stage 2 (register): ed = |exact - mult_p|, computed at 2*WIDTH+1 bits then truncated to 2*WIDTH (always fits).
    - If ed != 0, err_count += 1 and sum_ed += ed.
    - If ed > max_ed (strictly greater), update max_ed, worst_a, worst_b. Ties keep the earlier pair.
- DRAIN: MULT_LAT+2 cycles, flushing the pipeline; then DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - done rises 2^(2*WIDTH)+MULT_LAT+3 cycles after the edge that sampled start (65539 for defaults).
- Statistics hold stable from done until the next accepted start or RST.
- Accumulator widths are never exceeded: worst case sum_ed < 2^(4*WIDTH), err_count <= 2^(2*WIDTH). No saturation logic.
- mult_a/mult_b hold their last value (all-ones) through DRAIN/DONE/IDLE until the next start.

Optional Feature:
- Macro: APPROX_SIGNED_ERR_EN.
- Defined: sum_err accumulates signed (mult_p - exact), sign-extended to 4*WIDTH+1 bits, two's complement, updated in stage 2 alongside sum_ed. Used for mean error / bias.
- Undefined: accumulator logic is omitted and sum_err is tied to 0. The port is always present.

Test Plan (WIDTH=8; stub multiplier models replace the DUT multiplier):
- Exact stub (mult_p=a*b), MULT_LAT=0, start pulse -> done exactly 65539 cycles later; err_count=0, sum_ed=0, max_ed=0, worst_a=worst_b=0, sum_err=0.
- Stub exact except a=3,b=5 returns 16 -> err_count=1, sum_ed=1, max_ed=1, worst_a=3, worst_b=5, sum_err=+1 (macro on).
- Zero stub (mult_p=0) -> err_count=65025, sum_ed=1065369600, max_ed=65025, worst_a=255, worst_b=255, sum_err=-1065369600 (macro on) / 0 (macro off).
- MULT_LAT=2 with a 2-cycle registered exact stub -> all statistics 0, done at 65541 cycles; proves tag alignment.
- Zero stub, RST asserted at SWEEP cycle 1000 for one cycle -> all outputs 0, busy=0, no done. A following start gives the full zero-stub results.
- start held high for 10 cycles and pulsed again mid-sweep -> single sweep, single done at 65539 cycles after the first sample, results unchanged from the single-start run.
